// File: rtl/cla_serial_adder.sv
// cla_serial_adder: adds a+b+cin four bits per clock through an external carry_gen slice
module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cg_cin,
  output logic [3:0]       cg_p,
  output logic [3:0]       cg_g,
  input  logic [3:0]       cg_c
);
  localparam int N = WIDTH / 4;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  generate
    if (WIDTH < 4 || WIDTH % 4 != 0) begin : g_bad_width
      $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate
  state_t state;
  logic [WIDTH-1:0] ra, rb;
  logic carry;
  logic [IW-1:0] idx;
  logic run;
  assign run = state == RUN;
  assign cg_p = run ? ra[4*idx +: 4] ^ rb[4*idx +: 4] : 4'd0;
  assign cg_g = run ? ra[4*idx +: 4] & rb[4*idx +: 4] : 4'd0;
  assign cg_cin = run & carry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ra <= '0;
      rb <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ra <= a;
            rb <= b;
            carry <= cin;
            idx <= '0;
            sum <= '0;
            cout <= 1'b0;
            busy <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= cg_p ^ {cg_c[2:0], cg_cin};
          carry <= cg_c[3];
          idx <= idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            cout <= cg_c[3];
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: scoreboard bench for cla_serial_adder at WIDTH 16 and 4
module tb_cla_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start16 = 1'b0, cin16 = 1'b0, busy16, done16, cout16, cgcin16;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic [3:0] p16, g16, c16;
  logic start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4, cgcin4;
  logic [3:0] a4 = '0, b4 = '0, sum4, p4, g4, c4;
  logic [16:0] q16[$];
  logic [4:0] q4[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  function automatic logic [3:0] cgen(input logic [3:0] p, input logic [3:0] g, input logic ci);
    logic c;
    logic [3:0] r;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      c = g[i] | (p[i] & c);
      r[i] = c;
    end
    return r;
  endfunction
  assign c16 = cgen(p16, g16, cgcin16);
  assign c4 = cgen(p4, g4, cgcin4);
  cla_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .cg_cin(cgcin16),
    .cg_p(p16), .cg_g(g16), .cg_c(c16));
  cla_serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .cin(cin4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .cg_cin(cgcin4),
    .cg_p(p4), .cg_g(g4), .cg_c(c4));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
      else chk("result16", {15'd0, cout16, sum16}, {15'd0, q16.pop_front()});
    end
    if (done4) begin
      if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
      else chk("result4", {27'd0, cout4, sum4}, {27'd0, q4.pop_front()});
    end
    if (busy16 && done16) chk("busy_done16", 32'd1, 32'd0);
    if (busy4 && done4) chk("busy_done4", 32'd1, 32'd0);
  end
  task automatic add(input bit w4, input logic [15:0] x, input logic [15:0] y, input logic ci,
                     input logic [16:0] exp, input bit pg, input bit poke);
    int n;
    @(negedge clk);
    if (w4) begin
      q4.push_back(exp[4:0]);
      a4 = x[3:0]; b4 = y[3:0]; cin4 = ci; start4 = 1'b1;
    end else begin
      q16.push_back(exp);
      a16 = x; b16 = y; cin16 = ci; start16 = 1'b1;
    end
    @(negedge clk);
    start4 = 1'b0;
    start16 = 1'b0;
    n = 0;
    while (!(w4 ? done4 : done16) && n < 20) begin
      if (pg && !w4 && n < 4) begin
        chk("cg_p", {28'd0, p16}, {28'd0, (x[4*n +: 4] ^ y[4*n +: 4])});
        chk("cg_g", {28'd0, g16}, {28'd0, (x[4*n +: 4] & y[4*n +: 4])});
      end
      if (poke && n == 1) begin
        a16 = 16'h1111;
        start16 = 1'b1;
      end else start16 = 1'b0;
      @(negedge clk);
      n++;
    end
    start16 = 1'b0;
    if (n >= 20) chk("done_timeout", 32'd1, 32'd0);
    else chk(w4 ? "latency4" : "latency16", n + 1, w4 ? 32'd2 : 32'd5);
  endtask
  initial begin
    logic [15:0] x, y;
    logic ci;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset16", {9'd0, busy16, done16, cout16, cgcin16, p16, g16, sum16},
        {9'd0, 4'b0000, 8'h00, 16'h0000});
    chk("reset4", {18'd0, busy4, done4, cout4, cgcin4, p4, g4, sum4}, 32'd0);
    add(1'b0, 16'h0000, 16'h0000, 1'b0, 17'h00000, 1'b0, 1'b0);
    add(1'b0, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, 1'b0);
    add(1'b0, 16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b1, 1'b0);
    add(1'b0, 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b0, 1'b1);
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort16", {13'd0, busy16, done16, cout16, sum16}, 32'd0);
    repeat (6) @(negedge clk);
    add(1'b0, 16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0, 1'b0);
    add(1'b1, 16'h000F, 16'h0000, 1'b1, 17'h00010, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      ci = 1'($urandom_range(0, 1));
      add(1'b0, x, y, ci, {1'b0, x} + {1'b0, y} + {16'd0, ci}, 1'b0, 1'b0);
    end
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom_range(0, 15));
      y = 16'($urandom_range(0, 15));
      ci = 1'($urandom_range(0, 1));
      add(1'b1, x, y, ci, {1'b0, x} + {1'b0, y} + {16'd0, ci}, 1'b0, 1'b0);
    end
    repeat (4) @(negedge clk);
    chk("queue16_empty", q16.size(), 32'd0);
    chk("queue4_empty", q4.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
